imem_loader_axil: RTL and testbench
===================================

# imem_loader_axil

AXI4-Lite responder that loads program words into the core's 16-word instruction memory and controls core execution. It drives the instruction memory write port (`instruction_write`, `instruction_data`, `instruction_addr`), `run_pc` and `mem_reset_n` of the single-cycle RISC-V datapath. The host side is an AXI4-Lite master such as a PS or testbench. It is the writer end of the instruction-load interface the datapath consumes.

## Interface
- `ADDR_W`, default 6: AXI address width; decode uses `awaddr/araddr[4:2]`, and bits [1:0] are ignored.
- `clk` in 1: single clock for the bus and the core.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_awaddr` in ADDR_W, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in ADDR_W, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `instruction_write` out 1: one-cycle write strobe to the instruction memory.
- `instruction_data` out 32: instruction word to write.
- `instruction_addr` out 4: word index to write.
- `run_pc` out 1: PC advance enable.
- `mem_reset_n` out 1: active-low reset to the data memory.

## Operation
- Register map:
  - 0x00 CTRL (RW): bit0 RUN drives `run_pc`; bit1 DMEM_EN drives `mem_reset_n`.
  - 0x04 STATUS (RO): bit0 RUN; bits[8:4] LOADED, a count of LOAD_DATA writes that saturates at 16.
  - 0x08 LOAD_ADDR (RW): bits[3:0] next word index.
  - 0x0C LOAD_DATA (WO): a write stores the word and post-increments LOAD_ADDR modulo 16. Reads return 0.
  - 0x10 CYCLES: see Configuration.
- Write FSM states: W_IDLE, W_ADDR (address latched), W_DATA (data latched), W_RESP.
  - `s_awready` is high in W_IDLE and W_DATA.
  - `s_wready` is high in W_IDLE and W_ADDR.
  - When both channels are captured, whether in the same cycle or in either order, the write executes on that edge and the FSM enters W_RESP.
  - The FSM holds `s_bvalid` until `s_bready`, then returns to W_IDLE.
- LOAD_DATA write outcomes:
  - With RUN=0 and `s_wstrb`=4'hF: on the execute edge, `instruction_data`←wdata, `instruction_addr`←LOAD_ADDR, `instruction_write`←1 for exactly one cycle, LOAD_ADDR←LOAD_ADDR+1, and LOADED increments. BRESP=OKAY.
  - With RUN=1 or a partial strobe: no side effect, BRESP=SLVERR (2'b10).
- CTRL and LOAD_ADDR writes update only where `s_wstrb[0]`=1.
- STATUS writes and unmapped writes have no effect and return SLVERR.
- Read FSM states: R_IDLE (`s_arready`=1) and R_RESP (`s_rvalid`=1 until `s_rready`).
  - Read data is registered on the AR handshake edge.
  - Unmapped reads return 0 with SLVERR. All other reads return OKAY.
- Read and write channels are independent. A read that completes on the same edge as a write returns the pre-write value.

## Timing
- Reset values:
  - all readies 0 during reset, then `s_awready`=`s_wready`=`s_arready`=1;
  - `s_bvalid`=`s_rvalid`=0; `s_bresp`=`s_rresp`=0; `s_rdata`=0;
  - `instruction_write`=0, `instruction_data`=0, `instruction_addr`=0;
  - `run_pc`=0, `mem_reset_n`=0; LOAD_ADDR=0, LOADED=0.
- Write with AW and W valid together: handshake at edge N, `s_bvalid` and `instruction_write` both high after N. `instruction_write` is low after N+1.
- Back-to-back: the next write is accepted at the earliest one cycle after the B handshake.
- Read: AR handshake at edge N, `s_rvalid` high after N.
- `run_pc` and `mem_reset_n` change one cycle after the CTRL write execute edge.
- LOAD_ADDR wraps 15→0 after the write to index 15.
- An asserted reset mid-transaction aborts it immediately. No response is issued.

## Configuration
- `IMEM_LOADER_CYCLES_EN` defined:
  - 32-bit CYCLES counter at 0x10, reset 0, increments every cycle `run_pc`=1 and wraps at 2^32−1.
  - A write of any value clears it; clearing has priority over incrementing.
  - Reads return the count with OKAY.
- Undefined: 0x10 is unmapped (SLVERR on read and write) and no counter logic is built.

## Test plan
- After reset, read STATUS → rdata=0x0, OKAY. Check `run_pc`=0 and `mem_reset_n`=0.
- Write LOAD_ADDR=0, then 16 LOAD_DATA writes with 0x00000013+i → 16 single-cycle `instruction_write` pulses with addr 0..15 and matching data. STATUS LOADED=16. LOAD_ADDR reads 0 (wrap).
- Issue W two cycles before AW for LOAD_DATA=0xDEADBEEF → one pulse, BRESP=OKAY, `s_bvalid` held until `s_bready`, which is delayed 3 cycles.
- Write CTRL=0x3, then LOAD_DATA=0x1 → `run_pc`=1, `mem_reset_n`=1, BRESP=SLVERR, no `instruction_write` pulse.
- Write LOAD_DATA with wstrb=4'h3 while RUN=0 → SLVERR, no pulse. Read 0x14 → SLVERR, rdata 0.
- With `IMEM_LOADER_CYCLES_EN`: RUN=1 for 10 cycles then RUN=0 → CYCLES reads 10. Write 0x10 → reads 0.

Source files
------------

// File: rtl/imem_loader_axil.sv
// AXI4-Lite loader for the 16-word instruction memory plus core run/DMEM control.
// Optional CYCLES counter at 0x10 is built only when IMEM_LOADER_CYCLES_EN is defined.
module imem_loader_axil #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              instruction_write,
  output logic [31:0]       instruction_data,
  output logic [3:0]        instruction_addr,
  output logic              run_pc,
  output logic              mem_reset_n
);

  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;
  typedef enum logic {RIdle, RResp} rd_state_e;

  wr_state_e   wst_q, wst_d;
  rd_state_e   rst_q, rst_d;
  logic        ready_q;
  logic [2:0]  aw_idx_q, aw_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        run_q, run_d, dmem_q, dmem_d;
  logic [3:0]  la_q, la_d;
  logic [4:0]  loaded_q, loaded_d;
  logic        iw_q, iw_d;
  logic [31:0] idata_q, idata_d;
  logic [3:0]  iaddr_q, iaddr_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic        aw_hs, w_hs, ar_hs, exec, err;
  logic [2:0]  ex_idx;
  logic [31:0] ex_data;
  logic [3:0]  ex_strb;
  logic        unused_addr;

`ifdef IMEM_LOADER_CYCLES_EN
  logic [31:0] cycles_q, cycles_d;
  logic        cyc_clr;
`endif

  assign unused_addr = ^{s_awaddr, s_araddr};

  // Readies stay low until the first edge after reset release.
  assign s_awready = ready_q & ((wst_q == WIdle) | (wst_q == WData));
  assign s_wready  = ready_q & ((wst_q == WIdle) | (wst_q == WAddr));
  assign s_arready = ready_q & (rst_q == RIdle);
  assign s_bvalid  = (wst_q == WResp);
  assign s_rvalid  = (rst_q == RResp);
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign ar_hs     = s_arvalid & s_arready;

  assign s_bresp           = bresp_q;
  assign s_rresp           = rresp_q;
  assign s_rdata           = rdata_q;
  assign instruction_write = iw_q;
  assign instruction_data  = idata_q;
  assign instruction_addr  = iaddr_q;
  assign run_pc            = run_q;
  assign mem_reset_n       = dmem_q;

  // Latched halves are used only when the other channel arrived first.
  assign ex_idx  = (wst_q == WAddr) ? aw_idx_q : s_awaddr[4:2];
  assign ex_data = (wst_q == WData) ? wdata_q : s_wdata;
  assign ex_strb = (wst_q == WData) ? wstrb_q : s_wstrb;

  always_comb begin
    wst_d    = wst_q;
    aw_idx_d = aw_idx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    exec     = 1'b0;
    unique case (wst_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          exec = 1'b1;
        end else if (aw_hs) begin
          aw_idx_d = s_awaddr[4:2];
          wst_d    = WAddr;
        end else if (w_hs) begin
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
          wst_d   = WData;
        end
      end
      WAddr: exec = w_hs;
      WData: exec = aw_hs;
      WResp: if (s_bready) wst_d = WIdle;
      default: wst_d = WIdle;
    endcase
    if (exec) wst_d = WResp;
  end

  always_comb begin
    run_d    = run_q;
    dmem_d   = dmem_q;
    la_d     = la_q;
    loaded_d = loaded_q;
    iw_d     = 1'b0;
    idata_d  = idata_q;
    iaddr_d  = iaddr_q;
    bresp_d  = bresp_q;
    err      = 1'b0;
`ifdef IMEM_LOADER_CYCLES_EN
    cyc_clr  = 1'b0;
`endif
    if (exec) begin
      case (ex_idx)
        3'd0: if (ex_strb[0]) begin
          run_d  = ex_data[0];
          dmem_d = ex_data[1];
        end
        3'd2: if (ex_strb[0]) la_d = ex_data[3:0];
        3'd3: begin
          if (!run_q && (ex_strb == 4'hF)) begin
            iw_d    = 1'b1;
            idata_d = ex_data;
            iaddr_d = la_q;
            la_d    = la_q + 4'd1;
            if (loaded_q != 5'd16) loaded_d = loaded_q + 5'd1;
          end else begin
            err = 1'b1;
          end
        end
`ifdef IMEM_LOADER_CYCLES_EN
        3'd4: cyc_clr = 1'b1;
`endif
        default: err = 1'b1;
      endcase
      bresp_d = err ? 2'b10 : 2'b00;
    end
  end

`ifdef IMEM_LOADER_CYCLES_EN
  // Clear wins over the run-time increment.
  assign cycles_d = cyc_clr ? 32'd0 : (run_q ? cycles_q + 32'd1 : cycles_q);
`endif

  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rst_q)
      RIdle: if (ar_hs) begin
        rst_d   = RResp;
        rresp_d = 2'b00;
        case (s_araddr[4:2])
          3'd0:    rdata_d = {30'd0, dmem_q, run_q};
          3'd1:    rdata_d = {23'd0, loaded_q, 3'd0, run_q};
          3'd2:    rdata_d = {28'd0, la_q};
          3'd3:    rdata_d = 32'd0;
`ifdef IMEM_LOADER_CYCLES_EN
          3'd4:    rdata_d = cycles_q;
`endif
          default: begin
            rdata_d = 32'd0;
            rresp_d = 2'b10;
          end
        endcase
      end
      RResp: if (s_rready) rst_d = RIdle;
      default: rst_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wst_q    <= WIdle;
      rst_q    <= RIdle;
      ready_q  <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      run_q    <= 1'b0;
      dmem_q   <= 1'b0;
      la_q     <= '0;
      loaded_q <= '0;
      iw_q     <= 1'b0;
      idata_q  <= '0;
      iaddr_q  <= '0;
      bresp_q  <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      ready_q  <= 1'b1;
      aw_idx_q <= aw_idx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      run_q    <= run_d;
      dmem_q   <= dmem_d;
      la_q     <= la_d;
      loaded_q <= loaded_d;
      iw_q     <= iw_d;
      idata_q  <= idata_d;
      iaddr_q  <= iaddr_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef IMEM_LOADER_CYCLES_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycles_q <= '0;
    else          cycles_q <= cycles_d;
  end
`endif

endmodule

// File: tb/tb_imem_loader_axil.sv
// Directed bench for imem_loader_axil; also covers CYCLES when IMEM_LOADER_CYCLES_EN is set.
module tb_imem_loader_axil;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        instruction_write, run_pc, mem_reset_n;
  logic [31:0] instruction_data;
  logic [3:0]  instruction_addr;

  always #5 clk = ~clk;

  imem_loader_axil #(.ADDR_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .instruction_write(instruction_write), .instruction_data(instruction_data),
    .instruction_addr(instruction_addr), .run_pc(run_pc), .mem_reset_n(mem_reset_n)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pulse_data[$];
  logic [3:0]  pulse_addr[$];
  bit          iw_prev = 1'b0;
  bit          iw_long = 1'b0;
  logic        wr_iw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (instruction_write) begin
        pulse_data.push_back(instruction_data);
        pulse_addr.push_back(instruction_addr);
        if (iw_prev) iw_long = 1'b1;
      end
      iw_prev = instruction_write;
    end
  end

  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st,
                        output logic [1:0] resp);
    bit ok = 1'b0;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_awready && s_wready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("wr_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wr_iw = instruction_write;
    for (int i = 0; i < 20 && !s_bvalid; i++) @(negedge clk);
    if (!s_bvalid) check("bvalid_timeout", 32'd0, 32'd1);
    resp = s_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 1'b0;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("rd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 20 && !s_rvalid; i++) @(negedge clk);
    if (!s_rvalid) check("rvalid_timeout", 32'd0, 32'd1);
    d = s_rdata; resp = s_rresp;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;

  initial begin
    reset_n = 1'b0;
    s_awaddr = '0; s_araddr = '0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_bready = 1'b1; s_rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    check("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    check("rst_outs", {s_bresp, s_rresp, instruction_write, run_pc, mem_reset_n}, 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_iw_data", {instruction_data[27:0], instruction_addr}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("post_rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

    axi_rd(6'h04, rd, rr);
    check("status0_data", rd, 32'd0);
    check("status0_resp", {30'd0, rr}, 32'd0);
    check("run_pc0", {31'd0, run_pc}, 32'd0);
    check("mem_reset_n0", {31'd0, mem_reset_n}, 32'd0);

    axi_wr(6'h08, 32'd0, 4'hF, br);
    check("load_addr_wr_resp", {30'd0, br}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      axi_wr(6'h0C, 32'h13 + i, 4'hF, br);
      check("load_resp", {30'd0, br}, 32'd0);
      if (i == 0) check("iw_after_exec_edge", {31'd0, wr_iw}, 32'd1);
    end
    check("pulse_count16", pulse_data.size(), 32'd16);
    if (pulse_data.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        check("pulse_data", pulse_data[i], 32'h13 + i);
        check("pulse_addr", {28'd0, pulse_addr[i]}, i);
      end
    end
    axi_rd(6'h04, rd, rr);
    check("status_loaded16", rd, 32'h100);
    axi_rd(6'h08, rd, rr);
    check("load_addr_wrapped", rd, 32'd0);

    // W leads AW by two cycles; B held off for three cycles.
    s_bready = 1'b0;
    @(negedge clk);
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s_awaddr = 6'h0C; s_awvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bvalid_held", {31'd0, s_bvalid}, 32'd1);
    end
    check("w_first_bresp", {30'd0, s_bresp}, 32'd0);
    s_bready = 1'b1;
    @(posedge clk); #1;
    check("bvalid_dropped", {31'd0, s_bvalid}, 32'd0);
    check("pulse_count17", pulse_data.size(), 32'd17);
    if (pulse_data.size() >= 17) begin
      check("w_first_data", pulse_data[16], 32'hDEADBEEF);
      check("w_first_addr", {28'd0, pulse_addr[16]}, 32'd0);
    end
    axi_rd(6'h04, rd, rr);
    check("status_saturated", rd, 32'h100);

    axi_wr(6'h00, 32'h3, 4'hF, br);
    check("ctrl_resp", {30'd0, br}, 32'd0);
    check("run_pc1", {31'd0, run_pc}, 32'd1);
    check("mem_reset_n1", {31'd0, mem_reset_n}, 32'd1);
    axi_rd(6'h04, rd, rr);
    check("status_run", rd, 32'h101);
    axi_wr(6'h0C, 32'h1, 4'hF, br);
    check("load_while_run_resp", {30'd0, br}, 32'd2);
    check("load_while_run_nopulse", pulse_data.size(), 32'd17);

`ifdef IMEM_LOADER_CYCLES_EN
    axi_wr(6'h00, 32'h0, 4'hF, br);
    axi_wr(6'h10, 32'h0, 4'hF, br);
    check("cycles_clr_resp", {30'd0, br}, 32'd0);
    axi_wr(6'h00, 32'h1, 4'hF, br);
    repeat (8) @(posedge clk);
    axi_wr(6'h00, 32'h0, 4'hF, br);
    axi_rd(6'h10, rd, rr);
    check("cycles10", rd, 32'd10);
    check("cycles_rresp", {30'd0, rr}, 32'd0);
    axi_wr(6'h10, 32'h1234, 4'hF, br);
    axi_rd(6'h10, rd, rr);
    check("cycles_cleared", rd, 32'd0);
`else
    axi_rd(6'h10, rd, rr);
    check("cycles_off_rdata", rd, 32'd0);
    check("cycles_off_rresp", {30'd0, rr}, 32'd2);
    axi_wr(6'h10, 32'h0, 4'hF, br);
    check("cycles_off_bresp", {30'd0, br}, 32'd2);
`endif

    axi_wr(6'h00, 32'h0, 4'hF, br);
    check("run_pc_off", {31'd0, run_pc}, 32'd0);
    axi_wr(6'h0C, 32'h55, 4'h3, br);
    check("partial_strb_resp", {30'd0, br}, 32'd2);
    check("partial_strb_nopulse", pulse_data.size(), 32'd17);
    axi_rd(6'h14, rd, rr);
    check("unmapped_rdata", rd, 32'd0);
    check("unmapped_rresp", {30'd0, rr}, 32'd2);
    axi_wr(6'h04, 32'hFF, 4'hF, br);
    check("status_wr_resp", {30'd0, br}, 32'd2);
    axi_wr(6'h00, 32'h3, 4'h2, br);
    check("ctrl_strb0_ignored", {30'd0, mem_reset_n, run_pc}, 32'd0);
    axi_rd(6'h0C, rd, rr);
    check("load_data_rd_zero", rd, 32'd0);
    check("iw_single_cycle", {31'd0, iw_long}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
